sd_code_slewer: RTL and testbench

Slew-rate limiter that sits directly upstream of the first-order sigma-delta modulator in the VCXO tuning path. It accepts target DAC codes from the loop filter over a valid/ready handshake and clamps each to a safe range. It then ramps its registered output toward the target by at most STEP_MAX LSB every UPDATE_DIV clocks. The output drives the modulator's unsigned code input directly and stays constant between steps.

---
 rtl/sd_code_slewer_pkg.sv | 14 +
 rtl/sd_code_slewer_slew_step.sv | 33 +++
 rtl/sd_code_slewer.sv | 135 +++++++++++++
 tb/tb_sd_code_slewer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_code_slewer_pkg.sv
// Shared definitions for the sigma-delta tuning path: slewer FSM states and
// default sizing constants also used by the modulator instantiation.
package sd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } sd_state_t;

  localparam int unsigned SD_CODE_W     = 12;
  localparam int unsigned SD_RESET_CODE = 2048;
  localparam int unsigned SD_UPDATE_DIV = 1024;

endpackage

// File: rtl/sd_code_slewer_slew_step.sv
// One slew step: moves the code toward the target by at most STEP_MAX LSB,
// never past it, and flags when the stepped code lands on the target.
module sd_slew_step #(
  parameter int unsigned CODE_W   = 12,
  parameter int unsigned STEP_MAX = 16
) (
  input  logic [CODE_W-1:0] i_code_out,
  input  logic [CODE_W-1:0] i_target,
  output logic [CODE_W-1:0] o_next_code,
  output logic              o_reached
);

  // A step larger than the whole code range behaves exactly like "jump to target".
  localparam int unsigned   STEP_CAP = (STEP_MAX > (2 ** CODE_W)) ? (2 ** CODE_W) : STEP_MAX;
  localparam logic [CODE_W:0] STEP_L = (CODE_W + 1)'(STEP_CAP);

  logic signed [CODE_W:0] w_diff;
  logic        [CODE_W:0] w_mag;
  logic        [CODE_W:0] w_step;

  always_comb begin
    w_diff = $signed({1'b0, i_target}) - $signed({1'b0, i_code_out});
    w_mag  = w_diff[CODE_W] ? unsigned'(-w_diff) : unsigned'(w_diff);
    w_step = (w_mag > STEP_L) ? STEP_L : w_mag;
    if (w_diff[CODE_W]) begin
      o_next_code = i_code_out - w_step[CODE_W-1:0];
    end else begin
      o_next_code = i_code_out + w_step[CODE_W-1:0];
    end
    o_reached = (o_next_code == i_target);
  end

endmodule

// File: rtl/sd_code_slewer.sv
// Slew-rate limiter ahead of the sigma-delta modulator: clamps requested codes
// and ramps code_out toward the target in bounded steps every UPDATE_DIV clocks.
module sd_code_slewer
  import sd_pkg::*;
#(
  parameter int unsigned CODE_W     = SD_CODE_W,
  parameter int unsigned STEP_MAX   = 16,
  parameter int unsigned UPDATE_DIV = SD_UPDATE_DIV,
  parameter int unsigned CODE_MIN   = 0,
  parameter int unsigned CODE_MAX   = 4095,
  parameter int unsigned RESET_CODE = SD_RESET_CODE
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic [CODE_W-1:0] req_code,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              hold,
  output logic [CODE_W-1:0] code_out,
  output logic              code_strobe,
  output logic              clamp_hit,
  output logic              settled
);

  localparam int unsigned   CNT_W  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(UPDATE_DIV - 1);
  localparam logic [CODE_W-1:0] MIN_L      = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] MAX_L      = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] RST_L      = CODE_W'(RESET_CODE);

  sd_state_t         r_state, w_nxt_state;
  logic [CODE_W-1:0] r_target, w_nxt_target;
  logic [CODE_W-1:0] r_code, w_nxt_code;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic              r_strobe, w_nxt_strobe;
  logic              r_clamp;

  logic [CODE_W-1:0] w_clamped;
  logic              w_lo, w_hi, w_clip;
  logic              w_step_evt;
  logic [CODE_W-1:0] w_step_code;
  logic              w_reached;

  sd_slew_step #(
    .CODE_W  (CODE_W),
    .STEP_MAX(STEP_MAX)
  ) u_step (
    .i_code_out (r_code),
    .i_target   (r_target),
    .o_next_code(w_step_code),
    .o_reached  (w_reached)
  );

  always_comb begin
    w_lo       = $signed({1'b0, req_code}) < $signed({1'b0, MIN_L});
    w_hi       = $signed({1'b0, req_code}) > $signed({1'b0, MAX_L});
    w_clamped  = w_lo ? MIN_L : (w_hi ? MAX_L : req_code);
    w_clip     = req_valid && (w_lo || w_hi);
    w_step_evt = (r_state == SLEW) && (r_cnt == '0) && !hold;
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_target = r_target;
    w_nxt_code   = r_code;
    w_nxt_cnt    = r_cnt;
    w_nxt_strobe = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_nxt_target = w_clamped;
          if (w_clamped != r_code) begin
            w_nxt_cnt   = '0;
            w_nxt_state = SLEW;
          end
        end
      end
      SLEW: begin
        if (req_valid) begin
          w_nxt_target = w_clamped;
        end
        // A retarget landing on the step that reaches the old target keeps
        // the FSM in SLEW so IDLE always implies code_out == target.
        if (w_step_evt) begin
          if (r_target == r_code) begin
            if (!(req_valid && (w_clamped != r_code))) begin
              w_nxt_state = IDLE;
            end
          end else begin
            w_nxt_code   = w_step_code;
            w_nxt_cnt    = CNT_RELOAD;
            w_nxt_strobe = 1'b1;
            if (w_reached && !(req_valid && (w_clamped != w_step_code))) begin
              w_nxt_state = IDLE;
            end
          end
        end else if (!hold) begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      r_target <= RST_L;
      r_code   <= RST_L;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_clamp  <= 1'b0;
    end else begin
      r_target <= w_nxt_target;
      r_code   <= w_nxt_code;
      r_cnt    <= w_nxt_cnt;
      r_strobe <= w_nxt_strobe;
      r_clamp  <= w_clip;
    end
  end

  assign req_ready   = 1'b1;
  assign code_out    = r_code;
  assign code_strobe = r_strobe;
  assign clamp_hit   = r_clamp;
  assign settled     = (r_state == IDLE);

endmodule

// File: tb/tb_sd_code_slewer.sv
// Directed bench for sd_code_slewer: a clamp-range instance driven from a
// vector table, and a default-range instance exercising ramp timing, retarget, hold and reset.
module tb_sd_code_slewer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        global_rst;
  logic [11:0] a_req_code;
  logic        a_req_valid, a_hold, a_req_ready, a_strobe, a_clamp, a_settled;
  logic [11:0] a_code_out;
  logic [12:0] b_req_code;
  logic        b_req_valid, b_hold, b_req_ready, b_strobe, b_clamp, b_settled;
  logic [12:0] b_code_out;

  sd_code_slewer #(.UPDATE_DIV(4)) dut_a (
    .clk(clk), .global_rst(global_rst),
    .req_code(a_req_code), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .hold(a_hold), .code_out(a_code_out), .code_strobe(a_strobe),
    .clamp_hit(a_clamp), .settled(a_settled)
  );

  sd_code_slewer #(.CODE_W(13), .UPDATE_DIV(4), .CODE_MIN(200), .CODE_MAX(3000)) dut_b (
    .clk(clk), .global_rst(global_rst),
    .req_code(b_req_code), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .hold(b_hold), .code_out(b_code_out), .code_strobe(b_strobe),
    .clamp_hit(b_clamp), .settled(b_settled)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a_q_edge[$];
  int a_q_code[$];
  int b_strobes = 0;
  int b_clamps = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_strobe) begin
      a_q_edge.push_back(cyc);
      a_q_code.push_back(int'(a_code_out));
    end
    if (b_strobe) b_strobes++;
    if (b_clamp) b_clamps++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic req_a(input int code, output int k);
    @(negedge clk);
    a_req_code  = 12'(code);
    a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    a_req_valid = 1'b0;
  endtask

  task automatic pop_a(input string name, output int e, output int c);
    bit found = 1'b0;
    e = -1;
    c = -1;
    for (int t = 0; t < 2000; t++) begin
      if (a_q_edge.size() > 0) begin
        e = a_q_edge.pop_front();
        c = a_q_code.pop_front();
        found = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check({name, "_arrived"}, int'(found), 1);
  endtask

  task automatic wait_settled_a(input string name);
    bit found = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      #1;
      if (a_settled) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_settled"}, int'(found), 1);
  endtask

  typedef struct {
    int req;
    int exp_code;
    int exp_clamp;
    int exp_strobes;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k, k2, e, e2, c, s0, c0, lowcnt;
    int exp_codes[4];
    bit found;

    vecs[0] = '{5000, 3000, 1, 60};
    vecs[1] = '{100,  200,  1, 175};
    vecs[2] = '{0,    200,  1, 0};
    vecs[3] = '{2500, 2500, 0, 144};
    vecs[4] = '{3000, 3000, 0, 32};
    vecs[5] = '{8191, 3000, 1, 0};
    vecs[6] = '{200,  200,  0, 175};
    vecs[7] = '{199,  200,  1, 0};
    exp_codes = '{2064, 2080, 2096, 2100};

    global_rst  = 1'b1;
    a_req_code  = '0;
    a_req_valid = 1'b0;
    a_hold      = 1'b0;
    b_req_code  = '0;
    b_req_valid = 1'b0;
    b_hold      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code", int'(a_code_out), 2048);
    check("rst_settled", int'(a_settled), 1);
    check("rst_ready", int'(a_req_ready), 1);
    check("rst_strobe", int'(a_strobe), 0);
    check("rst_clamp", int'(b_clamp), 0);
    global_rst = 1'b0;

    repeat (5000) @(negedge clk);
    #1;
    check("idle_a_strobes", a_q_edge.size(), 0);
    check("idle_b_strobes", b_strobes, 0);
    check("idle_code", int'(a_code_out), 2048);
    check("idle_settled", int'(a_settled), 1);
    check("idle_ready", int'(b_req_ready), 1);

    // Clamp range instance: each vector ramps from where the previous one ended.
    for (int i = 0; i < 8; i++) begin
      s0 = b_strobes;
      c0 = b_clamps;
      @(negedge clk);
      b_req_code  = 13'(vecs[i].req);
      b_req_valid = 1'b1;
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 3000; t++) begin
        @(negedge clk);
        #1;
        if (b_settled) begin
          found = 1'b1;
          break;
        end
      end
      repeat (2) @(negedge clk);
      #1;
      check($sformatf("vec%0d_settled", i), int'(found), 1);
      check($sformatf("vec%0d_code", i), int'(b_code_out), vecs[i].exp_code);
      check($sformatf("vec%0d_clamp", i), b_clamps - c0, vecs[i].exp_clamp);
      check($sformatf("vec%0d_strobes", i), b_strobes - s0, vecs[i].exp_strobes);
    end

    // Ramp 2048 -> 2100 with UPDATE_DIV=4.
    a_q_edge.delete();
    a_q_code.delete();
    req_a(2100, k);
    check("ramp_settled_low", int'(a_settled), 0);
    for (int i = 0; i < 4; i++) begin
      pop_a($sformatf("ramp%0d", i), e, c);
      check($sformatf("ramp%0d_edge", i), e - k, 1 + 4 * i);
      check($sformatf("ramp%0d_code", i), c, exp_codes[i]);
    end
    check("ramp_settled_high", int'(a_settled), 1);

    // Mid-ramp retarget: 2100 -> 2300, then 2000 after the first step.
    req_a(2300, k);
    pop_a("rt_first", e, c);
    check("rt_first_edge", e - k, 1);
    check("rt_first_code", c, 2116);
    req_a(2000, k2);
    pop_a("rt_down", e, c);
    check("rt_down_edge", e - k, 5);
    check("rt_down_code", c, 2100);
    wait_settled_a("rt");
    check("rt_final", int'(a_code_out), 2000);

    // Request equal to code_out while idle.
    a_q_edge.delete();
    a_q_code.delete();
    lowcnt = 0;
    req_a(2000, k);
    if (!a_settled) lowcnt++;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      #1;
      if (!a_settled) lowcnt++;
    end
    check("eq_settled_low_cycles", lowcnt, 0);
    check("eq_strobes", a_q_edge.size(), 0);
    check("eq_code", int'(a_code_out), 2000);

    // Hold across two step slots.
    req_a(2100, k);
    pop_a("hold_first", e, c);
    check("hold_first_edge", e - k, 1);
    check("hold_first_code", c, 2016);
    a_hold = 1'b1;
    repeat (8) @(negedge clk);
    a_hold = 1'b0;
    #1;
    check("hold_frozen_strobes", a_q_edge.size(), 0);
    check("hold_frozen_code", int'(a_code_out), 2016);
    pop_a("hold_resume1", e2, c);
    check("hold_resume1_edge", e2 - e, 12);
    check("hold_resume1_code", c, 2032);
    pop_a("hold_resume2", e2, c);
    check("hold_resume2_edge", e2 - e, 16);
    check("hold_resume2_code", c, 2048);

    // Asynchronous reset mid-ramp.
    global_rst = 1'b1;
    #1;
    check("mrst_code", int'(a_code_out), 2048);
    check("mrst_settled", int'(a_settled), 1);
    check("mrst_strobe", int'(a_strobe), 0);
    @(negedge clk);
    global_rst = 1'b0;
    a_q_edge.delete();
    a_q_code.delete();
    req_a(2100, k);
    pop_a("post_rst", e, c);
    check("post_rst_edge", e - k, 1);
    check("post_rst_code", c, 2064);
    wait_settled_a("post_rst");
    check("post_rst_final", int'(a_code_out), 2100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
